// File: rtl/fifo_rd_unpacker.sv
// fifo_rd_unpacker: drains a synchronous FIFO into a 2-word buffer and
// serializes each word onto an OUT_W-bit valid/ready stream, LSB slice first.
//
// Output handshake: a beat transfers on a clock edge where m_valid && m_ready.
// Once m_valid is high it stays high, with m_data/m_last unchanged, until that
// beat transfers. m_last marks the final beat of each buffered word.
module fifo_rd_unpacker #(
    parameter int DATA_W = 128,
    parameter int OUT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rddata,
    output logic              fifo_rden,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_last
);

    localparam int BEATS = DATA_W / OUT_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic [DATA_W-1:0] buffer [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              inflight;   // fifo_rden of the previous cycle
    logic [1:0]        occ;        // words held in buffer (0..2)
    logic [BW-1:0]     beat;       // slice index within the head word
    logic [1:0]        load;       // held words plus the one being read
    logic [DATA_W-1:0] head;
    logic [OUT_W-1:0]  head_beats [BEATS];
    logic              xfer;
    logic              retire;

    // Issue a read only when a buffer slot is guaranteed free at capture time.
    assign load      = occ + {1'b0, inflight};
    assign fifo_rden = !reset && !fifo_empty && (load < 2'd2);

    assign head    = buffer[rd_ptr];
    assign m_valid = (occ != 2'd0);
    assign m_last  = m_valid && (beat == LAST_BEAT);
    assign m_data  = m_valid ? head_beats[beat] : '0;
    assign xfer    = m_valid && m_ready;
    assign retire  = xfer && m_last;

    // Split the head word into its output beats, beat 0 in the low bits.
    always_comb begin
        for (int i = 0; i < BEATS; i++) begin
            head_beats[i] = head[i*OUT_W +: OUT_W];
        end
    end

    // Buffer, pointers, occupancy and beat index; reset drops everything,
    // including any read still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            buffer[0] <= '0;
            buffer[1] <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            inflight  <= 1'b0;
            occ       <= 2'd0;
            beat      <= '0;
        end else begin
            inflight <= fifo_rden;
            if (inflight) begin
                buffer[wr_ptr] <= fifo_rddata;
                wr_ptr         <= ~wr_ptr;
            end
            if (xfer) begin
                beat <= m_last ? '0 : beat + 1'b1;
            end
            if (retire) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({inflight, retire})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// tb_fifo_rd_unpacker: randomized bench with a FIFO model, an expected beat
// queue built from the words pushed, and per-scenario timing checks.
module tb_fifo_rd_unpacker;

    localparam int DW = 128;
    localparam int OW = 32;
    localparam int NB = DW / OW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rddata = '0;
    logic          fifo_rden;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [OW-1:0] m_data;
    logic          m_last;

    logic [DW-1:0] fifo_mem [256];
    int            rd_idx = 0;
    int            wr_idx = 0;
    logic          hold_empty = 1'b0;

    logic [OW:0]   exp_q [$];   // {last, data} per expected beat
    int            total = 0;
    int            bad = 0;
    int            reads = 0;
    int            retired = 0;
    logic          held_v = 1'b0;
    logic [OW-1:0] held_d = '0;
    logic          held_l = 1'b0;

    fifo_rd_unpacker #(.DATA_W(DW), .OUT_W(OW)) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_rddata (fifo_rddata),
        .fifo_rden   (fifo_rden),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last)
    );

    // clock / reset
    always #5 clk = ~clk;

    // FIFO model: read data appears the cycle after fifo_rden; garbage otherwise
    assign fifo_empty = hold_empty || (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (fifo_rden) begin
            fifo_rddata <= fifo_mem[rd_idx % 256];
            rd_idx      <= rd_idx + 1;
        end else begin
            fifo_rddata <= {$urandom, $urandom, $urandom, $urandom};
        end
        if (reset) begin
            reads   <= 0;
            retired <= 0;
        end else begin
            if (fifo_rden) reads <= reads + 1;
            if (m_valid && m_ready && m_last) retired <= retired + 1;
        end
    end

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [OW:0] e;
        if (!reset) begin
            total++;
            if (fifo_rden && fifo_empty) begin
                bad++;
                $display("FAIL rden_when_empty: fifo_rden=%0b fifo_empty=%0b required rden=0", fifo_rden, fifo_empty);
            end
            total++;
            if ((reads - retired > 2) || (reads - retired == 2 && fifo_rden)) begin
                bad++;
                $display("FAIL occupancy: outstanding=%0d fifo_rden=%0b required <=2 and no read at 2", reads - retired, fifo_rden);
            end
            if (held_v) begin
                total++;
                if (!m_valid || m_data !== held_d || m_last !== held_l) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%0b d=%h l=%0b required v=1 d=%h l=%0b", m_valid, m_data, m_last, held_d, held_l);
                end
            end
            if (m_valid && m_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got d=%h l=%0b with no beat expected", m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin
                        bad++;
                        $display("FAIL beat: got l=%0b d=%h required l=%0b d=%h", m_last, m_data, e[OW], e[OW-1:0]);
                    end
                end
            end
            held_v = m_valid && !m_ready;
            held_d = m_data;
            held_l = m_last;
        end else begin
            held_v = 1'b0;
        end
    end

    // driver tasks
    task automatic push_word(input logic [DW-1:0] w);
        fifo_mem[wr_idx % 256] = w;
        for (int b = 0; b < NB; b++) begin
            exp_q.push_back({(b == NB - 1), w[b*OW +: OW]});
        end
        wr_idx = wr_idx + 1;
    endtask

    task automatic drain(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        m_ready = 1'b1;
        reset   = 1'b1;
        push_word(128'h44444444_33333333_22222222_11111111);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (fifo_rden !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs: rden=%0b v=%0b d=%h l=%0b required all 0", fifo_rden, m_valid, m_data, m_last);
            end
        end
    endtask

    task automatic test_single();
        int rd_cnt = 0, rd_cyc = -1, v_cnt = 0, first_v = -1, last_cyc = -1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (fifo_rden) begin
                rd_cnt++;
                if (rd_cyc < 0) rd_cyc = k;
            end
            if (m_valid) begin
                v_cnt++;
                if (first_v < 0) first_v = k;
                if (m_last) last_cyc = k;
            end
        end
        total++;
        if (rd_cnt != 1) begin
            bad++;
            $display("FAIL single_reads: got %0d read pulses required 1", rd_cnt);
        end
        total++;
        if (rd_cyc < 0 || first_v - rd_cyc != 2) begin
            bad++;
            $display("FAIL single_latency: read cycle %0d first beat cycle %0d required gap 2", rd_cyc, first_v);
        end
        total++;
        if (v_cnt != NB || last_cyc != first_v + NB - 1) begin
            bad++;
            $display("FAIL single_beats: got %0d valid cycles last at %0d required %0d ending at %0d", v_cnt, last_cyc, NB, first_v + NB - 1);
        end
    endtask

    task automatic test_stream();
        int hs = 0, gaps = 0, lasts = 0;
        bit started = 1'b0;
        @(posedge clk);
        #1;
        m_ready    = 1'b1;
        hold_empty = 1'b1;
        for (int i = 0; i < 8; i++) push_word(rand_word());
        @(posedge clk);
        #1;
        hold_empty = 1'b0;
        for (int k = 0; k < 80 && hs < 8 * NB; k++) begin
            @(negedge clk);
            if (m_valid) begin
                started = 1'b1;
                hs++;
                if (m_last) lasts++;
            end else if (started) begin
                gaps++;
            end
        end
        total++;
        if (hs != 8 * NB || gaps != 0) begin
            bad++;
            $display("FAIL stream: got %0d beats with %0d gaps required %0d beats 0 gaps", hs, gaps, 8 * NB);
        end
        total++;
        if (lasts != 8) begin
            bad++;
            $display("FAIL stream_last: got %0d last beats required 8", lasts);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (m_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_idle: m_valid=%0b required 0", m_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        int stalls = 0;
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) push_word(rand_word());
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            m_ready = pat[3 - (i % 4)];
            @(negedge clk);
            if (m_valid && !m_ready) stalls++;
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        m_ready = 1'b1;
        total++;
        if (!ok || stalls == 0) begin
            bad++;
            $display("FAIL backpressure: left %0d beats, %0d stalls seen required 0 left and stalls>0", exp_q.size(), stalls);
        end
    endtask

    task automatic test_empty_guard();
        bit ok;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        push_word(rand_word());
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (fifo_empty) begin
                total++;
                if (fifo_rden !== 1'b0) begin
                    bad++;
                    $display("FAIL empty_guard: fifo_rden=%0b while empty required 0", fifo_rden);
                end
            end
        end
        total++;
        if (m_valid !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL empty_drained: m_valid=%0b pending=%0d required 0 and 0", m_valid, exp_q.size());
        end
        @(posedge clk);
        #1;
        push_word(rand_word());
        drain(30, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL empty_resume: %0d beats pending required 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0 && (wr_idx - rd_idx) < 200) push_word(rand_word());
            m_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain(600, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL random_drain: %0d beats pending required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int hs = 0;
        bit seen = 1'b0;
        bit ok;
        logic [DW-1:0] wd;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        push_word(rand_word());
        push_word(rand_word());
        for (int k = 0; k < 20 && hs < 2; k++) begin
            @(negedge clk);
            if (m_valid && m_ready) hs++;
        end
        @(posedge clk);
        #1;
        reset   = 1'b1;
        m_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        total++;
        if (fifo_rden !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_rden: fifo_rden=%0b required 0", fifo_rden);
        end
        @(negedge clk);
        total++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_outputs: v=%0b d=%h l=%0b required all 0", m_valid, m_data, m_last);
        end
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_ready = 1'b1;
        wd = rand_word();
        push_word(wd);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (m_valid) begin
                seen = 1'b1;
                total++;
                if (m_data !== wd[OW-1:0] || m_last !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_mid_next: got d=%h l=%0b required d=%h l=0", m_data, m_last, wd[OW-1:0]);
                end
            end
        end
        drain(30, ok);
        total++;
        if (!seen || !ok) begin
            bad++;
            $display("FAIL reset_mid_drain: seen=%0b pending=%0d required seen=1 pending=0", seen, exp_q.size());
        end
    endtask

    // test sequence and final report
    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_empty_guard();
        test_random();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
